// File: rtl/y86_defs.sv
// Shared Y86-64 encodings used by the pipeline controller: instruction codes,
// status codes, the "no register" id and the controller state encoding.
package y86_defs;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;
    localparam logic [3:0] RNONE   = 4'hF;

    localparam logic [2:0] SBUB = 3'd0;
    localparam logic [2:0] SAOK = 3'd1;
    localparam logic [2:0] SHLT = 3'd2;
    localparam logic [2:0] SADR = 3'd3;
    localparam logic [2:0] SINS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } ctrl_state_t;

    // A status that must stop the machine once it reaches write-back.
    function automatic logic is_exc(input logic [2:0] s);
        return (s == SHLT) || (s == SADR) || (s == SINS);
    endfunction

endpackage

// File: rtl/pipe_hazard.sv
// Pure combinational hazard decode: load-use, mispredict, pending ret and
// exception status in the M and W stages.
module pipe_hazard
    import y86_defs::*;
(
    input  logic [3:0] d_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] e_icode,
    input  logic [3:0] e_dstM,
    input  logic       e_cnd,
    input  logic [3:0] m_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] w_stat,
    output logic       lu,
    output logic       mis,
    output logic       retp,
    output logic       m_exc,
    output logic       w_exc
);

    logic e_is_load;

    assign e_is_load = (e_icode == IMRMOVQ) || (e_icode == IPOPQ);
    assign lu    = e_is_load && (e_dstM != RNONE) &&
                   ((e_dstM == d_srcA) || (e_dstM == d_srcB));
    assign mis   = (e_icode == IJXX) && !e_cnd;
    assign retp  = (d_icode == IRET) || (e_icode == IRET) || (m_icode == IRET);
    assign m_exc = is_exc(m_stat);
    assign w_exc = is_exc(w_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard/sequencing controller: stall/bubble generation,
// IDLE/RUN/HALT sequencing and performance counters.
module pipe_ctrl
    import y86_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       d_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       e_icode,
    input  logic [3:0]       e_dstM,
    input  logic             e_cnd,
    input  logic [3:0]       m_icode,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       w_stat,
    input  logic [3:0]       w_icode,
    output logic             f_stall,
    output logic             d_stall,
    output logic             w_stall,
    output logic             d_bubble,
    output logic             e_bubble,
    output logic             m_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       proc_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    ctrl_state_t state;
    logic        lu, mis, retp, m_exc, w_exc;
    logic        unused_w_icode;

    // W icode is carried for completeness; retirement is judged on status alone.
    assign unused_w_icode = ^w_icode;

    pipe_hazard u_hazard (
        .d_icode (d_icode),
        .d_srcA  (d_srcA),
        .d_srcB  (d_srcB),
        .e_icode (e_icode),
        .e_dstM  (e_dstM),
        .e_cnd   (e_cnd),
        .m_icode (m_icode),
        .m_stat  (m_stat),
        .w_stat  (w_stat),
        .lu      (lu),
        .mis     (mis),
        .retp    (retp),
        .m_exc   (m_exc),
        .w_exc   (w_exc)
    );

    always_comb begin
        f_stall  = 1'b1;
        d_stall  = 1'b1;
        w_stall  = 1'b1;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        set_cc   = 1'b0;
        if (state == ST_RUN) begin
            f_stall  = lu | retp;
            d_stall  = lu;
            // A load-use stall holds D, so the ret bubble waits until D moves.
            d_bubble = mis | (!lu & retp);
            e_bubble = mis | lu;
            m_bubble = m_exc | w_exc;
            w_stall  = w_exc;
            set_cc   = (e_icode == IOPQ) & !m_exc & !w_exc;
        end
    end

    assign halted = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            proc_stat <= SAOK;
            cyc_cnt   <= '0;
            ret_cnt   <= '0;
            stall_cnt <= '0;
            mis_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (run) state <= ST_RUN;
                end
                ST_RUN: begin
                    cyc_cnt <= cyc_cnt + CNT_W'(1);
                    if (w_stat == SAOK && !w_exc) ret_cnt <= ret_cnt + CNT_W'(1);
                    if (lu)  stall_cnt <= stall_cnt + CNT_W'(1);
                    if (mis) mis_cnt   <= mis_cnt + CNT_W'(1);
                    if (w_exc) begin
                        state     <= ST_HALT;
                        proc_stat <= w_stat;
                    end
                end
                ST_HALT: state <= ST_HALT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a rule-level reference model checked every
// cycle, plus hand-computed literal checkpoints along the scenario.
module tb_pipe_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             run;
    logic [3:0]       d_icode, d_srcA, d_srcB, e_icode, e_dstM, m_icode, w_icode;
    logic             e_cnd;
    logic [2:0]       m_stat, w_stat;
    logic             f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc, halted;
    logic [2:0]       proc_stat;
    logic [CNT_W-1:0] cyc_cnt, ret_cnt, stall_cnt, mis_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    // Reference model: running/halted flags, final status, counters.
    bit               md_running = 1'b0;
    bit               md_halted  = 1'b0;
    logic [2:0]       md_pstat   = 3'd1;
    logic [CNT_W-1:0] md_cyc = '0, md_ret = '0, md_stall = '0, md_mis = '0;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run),
        .d_icode(d_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .e_icode(e_icode), .e_dstM(e_dstM), .e_cnd(e_cnd),
        .m_icode(m_icode), .m_stat(m_stat), .w_stat(w_stat), .w_icode(w_icode),
        .f_stall(f_stall), .d_stall(d_stall), .w_stall(w_stall),
        .d_bubble(d_bubble), .e_bubble(e_bubble), .m_bubble(m_bubble),
        .set_cc(set_cc), .halted(halted), .proc_stat(proc_stat),
        .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt), .stall_cnt(stall_cnt), .mis_cnt(mis_cnt)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_exc_stat(input logic [2:0] s);
        return s == 3'd2 || s == 3'd3 || s == 3'd4;
    endfunction

    function automatic bit m_lu();
        return (e_icode == 4'h5 || e_icode == 4'hB) && e_dstM != 4'hF &&
               (e_dstM == d_srcA || e_dstM == d_srcB);
    endfunction

    function automatic bit m_mis();
        return e_icode == 4'h7 && !e_cnd;
    endfunction

    function automatic bit m_retp();
        return d_icode == 4'h9 || e_icode == 4'h9 || m_icode == 4'h9;
    endfunction

    // Model state update on the same edge the DUT uses.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_running = 1'b0;
            md_halted  = 1'b0;
            md_pstat   = 3'd1;
            md_cyc = '0; md_ret = '0; md_stall = '0; md_mis = '0;
        end else if (md_running) begin
            md_cyc = md_cyc + 1;
            if (w_stat == 3'd1) md_ret = md_ret + 1;
            if (m_lu()) md_stall = md_stall + 1;
            if (m_mis()) md_mis = md_mis + 1;
            if (m_exc_stat(w_stat)) begin
                md_running = 1'b0;
                md_halted  = 1'b1;
                md_pstat   = w_stat;
            end
        end else if (!md_halted && run) begin
            md_running = 1'b1;
        end
    end

    // Scoreboard compare on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [6:0] exp_ctl;
            if (md_running)
                exp_ctl = {m_lu() | m_retp(), m_lu(), m_exc_stat(w_stat),
                           m_mis() | (!m_lu() & m_retp()), m_mis() | m_lu(),
                           m_exc_stat(m_stat) | m_exc_stat(w_stat),
                           e_icode == 4'h6 && !m_exc_stat(m_stat) && !m_exc_stat(w_stat)};
            else
                exp_ctl = 7'b1110000;
            check("ctl{f,d,w_stall,d,e,m_bubble,set_cc}",
                  {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble, set_cc}, exp_ctl);
            check("halted", halted, md_halted);
            check("proc_stat", proc_stat, md_pstat);
            check("cyc_cnt", cyc_cnt, md_cyc);
            check("ret_cnt", ret_cnt, md_ret);
            check("stall_cnt", stall_cnt, md_stall);
            check("mis_cnt", mis_cnt, md_mis);
        end
    end

    // Driver tasks
    task automatic drive_nops();
        d_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF;
        e_icode = 4'h1; e_dstM = 4'hF; e_cnd = 1'b0;
        m_icode = 4'h1; m_stat = 3'd1; w_stat = 3'd1; w_icode = 4'h1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_run();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        run   = 1'b0;
        drive_nops();
        cmp_en = 1'b1;
        step(2);
        check("reset f_stall", f_stall, 1'b1);
        check("reset halted", halted, 1'b0);
        check("reset proc_stat", proc_stat, 3'd1);
        check("reset cyc_cnt", cyc_cnt, 0);
        rst_n = 1'b1;
        step(2);
        check("idle cyc_cnt frozen", cyc_cnt, 0);

        start_run();
        // Load-use on %rbx (3)
        e_icode = 4'h5; e_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        check("lu stalls/bubbles", {f_stall, d_stall, e_bubble, d_bubble}, 4'b1110);
        step(1);
        check("lu stall_cnt", stall_cnt, 1);
        drive_nops();

        // Mispredict held three cycles
        e_icode = 4'h7; e_cnd = 1'b0;
        #1;
        check("mis bubbles", {d_bubble, e_bubble, f_stall}, 3'b110);
        step(3);
        check("mis_cnt x3", mis_cnt, 3);
        drive_nops();

        // ret travelling D -> E -> M
        d_icode = 4'h9;
        #1; check("ret in D", {f_stall, d_bubble}, 2'b11);
        step(1); d_icode = 4'h1; e_icode = 4'h9;
        #1; check("ret in E", {f_stall, d_bubble}, 2'b11);
        step(1); e_icode = 4'h1; m_icode = 4'h9;
        #1; check("ret in M", {f_stall, d_bubble}, 2'b11);
        step(1); m_icode = 4'h1;
        // ret in D combined with load-use via srcB
        d_icode = 4'h9; e_icode = 4'hB; e_dstM = 4'h4; d_srcB = 4'h4;
        #1; check("ret+lu", {f_stall, d_stall, d_bubble, e_bubble}, 4'b1101);
        step(1);
        drive_nops();

        // Exception gating of set_cc
        e_icode = 4'h6;
        #1; check("opq set_cc", set_cc, 1'b1);
        m_stat = 3'd3;
        #1; check("m exc gating", {set_cc, m_bubble}, 2'b01);
        step(1);
        drive_nops();
        step(2);

        // Asynchronous reset mid-RUN, between edges
        #2 rst_n = 1'b0;
        #1;
        check("async rst outputs", {f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble}, 6'b111000);
        check("async rst cnts", {cyc_cnt, stall_cnt, mis_cnt}, 96'd0);
        check("async rst pstat", proc_stat, 3'd1);
        step(1);
        rst_n = 1'b1;
        step(1);

        start_run();
        step(5);
        check("rerun cyc_cnt", cyc_cnt, 5);
        check("rerun ret_cnt", ret_cnt, 5);

        // Halt retires in W
        e_icode = 4'h6; w_stat = 3'd2;
        #1; check("halt cycle", {w_stall, m_bubble, set_cc, halted}, 4'b1100);
        step(1);
        drive_nops();
        check("halted", halted, 1'b1);
        check("halt proc_stat", proc_stat, 3'd2);
        run = 1'b1;
        step(4);
        check("halt absorbing", halted, 1'b1);
        check("frozen cnts", {cyc_cnt, ret_cnt, stall_cnt, mis_cnt}, {32'd6, 32'd5, 32'd0, 32'd0});
        run = 1'b0;
        step(1);
        cmp_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
